// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory-bus responder.
//   state_t : responder FSM states
//   word_t  : one bus word
//   addr_t  : byte address on the bus
//   idx_t   : word index into storage (addr >> 1)
//   CNT_W   : width of the latency down-counter
package mem_responder_pkg;

  localparam int ADD_WIDTH  = 13;
  localparam int DATA_WIDTH = 16;
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    HOLD    = 2'd3
  } state_t;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADD_WIDTH-1:0]  addr_t;
  typedef logic [ADD_WIDTH-2:0]  idx_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response signals of the CPU memory bus (the shared tristate data
// bus stays a plain inout on the responder).
//   addr     : byte address, driven by the CPU sequencer
//   cs_input : chip select, request valid while high
//   we / oe  : write / read request
//   rdy      : access complete, driven by the responder
//   err      : misaligned, we&oe conflict or parity error, driven by the responder
interface mem_responder_if #(
  parameter int add_width  = 13,
  parameter int data_width = 16
) ();

  logic [add_width-1:0] addr;
  logic                 cs_input;
  logic                 we;
  logic                 oe;
  logic                 rdy;
  logic                 err;

  modport master (
    output addr, cs_input, we, oe,
    input  rdy, err
  );

  modport slave (
    input  addr, cs_input, we, oe,
    output rdy, err
  );

endinterface

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous word storage: one write port and a registered read
// port sharing one index. Contents have no reset.
//   clk   : clock
//   wr_en : write wdata to mem[idx] at posedge
//   rd_en : load mem[idx] into rdata at posedge
//   idx   : word index
//   wdata : write word
//   rdata : registered read word
module mem_array #(
  parameter int depth = 4096,
  parameter int width = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [$clog2(depth)-1:0] idx,
  input  logic [width-1:0]         wdata,
  output logic [width-1:0]         rdata
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= wdata;
    if (rd_en) rdata <= mem[idx];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the CPU memory bus. Samples requests, models fixed
// read/write wait states, drives the tristate data bus on reads and commits
// writes to word storage. rdy/err let the CPU sequencer stop counting cycles.
//   clk   : clock
//   rst_n : asynchronous active-low reset (storage contents are kept)
//   bus   : addr/cs_input/we/oe in, rdy/err out (slave modport)
//   data  : shared data bus, driven only in HOLD of a read
// Build option: define PARITY_EN to store an even-parity bit per word and flag
// read parity mismatches on err.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for cs_input with we or oe
// RD_WAIT | counting read wait states; array read issued on the last one
// WR_WAIT | counting write wait states; commit on the last one
// HOLD    | access done, rdy=1, held until the request changes or drops
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int add_width     = ADD_WIDTH,
  parameter int data_width    = DATA_WIDTH,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_responder_if.slave        bus,
  inout  wire  [data_width-1:0] data
);

`ifdef PARITY_EN
  localparam int STORE_W = data_width + 1;
`else
  localparam int STORE_W = data_width;
`endif

  localparam int DEPTH = 2 ** (add_width - 1);

  // Down-counter preload: the sample edge is edge 0, terminal count 0 is
  // reached on the edge before the final one, so the final edge sees cnt==0.
  localparam logic [CNT_W-1:0] RD_START = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_START = CNT_W'(WRITE_LATENCY - 1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [add_width-1:0]   addr_q;
  logic                   we_q, oe_q;
  logic                   err_req_q;
  logic [data_width-1:0]  wdata_q;
  logic                   rdy_q, err_q;
  logic                   mem_we, mem_re;
  logic                   sample;
  logic                   req_changed;
  logic [STORE_W-1:0]     store_wdata;
  logic [STORE_W-1:0]     rd_word;
  logic                   drive_en;
  logic [data_width-1:0]  rd_val;
  logic                   par_err;

  assign sample      = (state_q == IDLE) && bus.cs_input && (bus.we || bus.oe);
  assign req_changed = !bus.cs_input || (bus.addr != addr_q) ||
                       (bus.we != we_q) || (bus.oe != oe_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= (state_d == HOLD);
      err_q   <= (state_d == HOLD) && err_req_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      we_q      <= 1'b0;
      oe_q      <= 1'b0;
      err_req_q <= 1'b0;
      wdata_q   <= '0;
    end else if (sample) begin
      addr_q    <= bus.addr;
      we_q      <= bus.we;
      oe_q      <= bus.oe;
      err_req_q <= bus.addr[0] || (bus.we && bus.oe);
      if (bus.we) wdata_q <= data;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample && bus.we) begin
          state_d = WR_WAIT;
          cnt_d   = WR_START;
        end else if (sample) begin
          state_d = RD_WAIT;
          cnt_d   = RD_START;
        end
      end
      RD_WAIT: begin
        if (!bus.cs_input) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = HOLD;
          mem_re  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR_WAIT: begin
        if (!bus.cs_input) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = HOLD;
          mem_we  = !addr_q[0];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (req_changed) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PARITY_EN
  assign store_wdata = {^wdata_q, wdata_q};
  assign par_err     = (state_q == HOLD) && !we_q && !addr_q[0] && (^rd_word);
`else
  assign store_wdata = wdata_q;
  assign par_err     = 1'b0;
`endif

  mem_array #(
    .depth (DEPTH),
    .width (STORE_W)
  ) u_array (
    .clk   (clk),
    .wr_en (mem_we),
    .rd_en (mem_re),
    .idx   (addr_q[add_width-1:1]),
    .wdata (store_wdata),
    .rdata (rd_word)
  );

  // Release is combinational on the live request so the bus frees up the
  // moment the initiator drops oe or raises we, before the FSM leaves HOLD.
  assign drive_en = (state_q == HOLD) && !we_q &&
                    bus.cs_input && bus.oe && !bus.we;
  assign rd_val   = addr_q[0] ? '0 : rd_word[data_width-1:0];
  assign data     = drive_en ? rd_val : 'z;

  assign bus.rdy = rdy_q;
  assign bus.err = err_q || par_err;

endmodule
